// File: rtl/float_to_int_iter.sv
// Multi-cycle IEEE-754 float -> integer converter (signed/unsigned, trunc/RNE, saturating).
// Latency: ceil((e+1)/BPC)+1 cycles for e >= 0, 1 cycle for |x| < 1, 0 for zero/NaN/Inf/overflow.
// Backpressure: one conversion in flight; inTrigger is accepted only while outReady=1, ignored otherwise.
// Ports: clk/rst_n; inTrigger + inData {sign,exp,man} + inSigned/inRound captured on accept;
//        outReady (idle, results valid), outData, outInvalid (saturated), outInexact (fraction lost).
module float_to_int_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 64,
  parameter int BPC   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inTrigger,
  input  logic [EXP_W+MAN_W:0]   inData,
  input  logic                   inSigned,
  input  logic                   inRound,
  output logic                   outReady,
  output logic                   outInvalid,
  output logic                   outInexact,
  output logic [INT_W-1:0]       outData
);

  localparam int SW   = MAN_W + 1;           // significand width incl. hidden bit
  localparam int MW   = INT_W + 1;           // magnitude keeps the rounding carry
  localparam int RW   = $clog2(INT_W + 1);
  localparam int EW   = EXP_W + RW + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] INT_E  = EW'(INT_W);
  localparam logic [RW-1:0]        BPC_R  = RW'(BPC);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND} state_t;
  state_t state, stateNext;

  function automatic logic [INT_W-1:0] satHigh(input logic s);
    return s ? {1'b0, {(INT_W-1){1'b1}}} : {INT_W{1'b1}};
  endfunction

  function automatic logic [INT_W-1:0] satLow(input logic s);
    return s ? {1'b1, {(INT_W-1){1'b0}}} : {INT_W{1'b0}};
  endfunction

  // Input decode, used only on the accepting edge
  logic                   inSign;
  logic [EXP_W-1:0]       inExp;
  logic [MAN_W-1:0]       inMan;
  logic signed [EW-1:0]   eVal;
  logic                   isZero, isNan, overflow, special, accept;
  logic [INT_W-1:0]       satIn;

  assign inSign   = inData[EXP_W+MAN_W];
  assign inExp    = inData[MAN_W +: EXP_W];
  assign inMan    = inData[MAN_W-1:0];
  assign eVal     = $signed({{(EW-EXP_W){1'b0}}, inExp}) - BIAS_E;
  assign isZero   = (inExp == '0);
  assign isNan    = (&inExp) && (inMan != '0);
  // Inf and any exponent past the integer width saturate by sign; NaN goes low
  assign overflow = (&inExp) || (eVal >= INT_E);
  assign special  = isZero || overflow;
  assign satIn    = (isNan || inSign) ? satLow(inSigned) : satHigh(inSigned);
  assign accept   = inTrigger && outReady;

  // Captured operation
  logic              sgnR, signedR, roundR;
  logic [MW-1:0]     mag;
  logic [SW-1:0]     sigSh;      // unconsumed significand bits, MSB first
  logic [RW-1:0]     remaining;  // integer bits still to shift in

  // SHIFT datapath: take the next n significand bits (zeros once exhausted)
  logic [RW-1:0]     n;
  logic [BPC-1:0]    chunk;
  logic [MW-1:0]     magShift;

  assign n        = (remaining < BPC_R) ? remaining : BPC_R;
  assign chunk    = BPC'({sigSh, {BPC{1'b0}}} >> SW);
  assign magShift = (mag << n) | MW'(chunk >> (BPC_R - n));

  // ROUND datapath: first leftover bit is guard, the rest fold into sticky
  logic              guard, sticky, inc, inRange;
  logic [MW-1:0]     mRnd;
  logic [INT_W-1:0]  result, satR;

  assign guard  = sigSh[SW-1];
  assign sticky = |sigSh[SW-2:0];
  assign inc    = roundR && guard && (sticky || mag[0]);
  assign mRnd   = mag + MW'(inc);
  assign result = sgnR ? -mRnd[INT_W-1:0] : mRnd[INT_W-1:0];
  assign satR   = sgnR ? satLow(signedR) : satHigh(signedR);

  always_comb begin
    inRange = 1'b0;
    if (signedR) begin
      if (sgnR) inRange = !mRnd[INT_W] && (!mRnd[INT_W-1] || (mRnd[INT_W-2:0] == '0));
      else      inRange = (mRnd[INT_W:INT_W-1] == 2'b00);
    end else begin
      if (sgnR) inRange = (mRnd == '0);
      else      inRange = !mRnd[INT_W];
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // FSM: next state
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept && !special) stateNext = (eVal < 0) ? ROUND : SHIFT;
      SHIFT:   if (remaining <= BPC_R) stateNext = ROUND;
      ROUND:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    outReady = (state == IDLE);
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgnR       <= 1'b0;
      signedR    <= 1'b0;
      roundR     <= 1'b0;
      mag        <= '0;
      sigSh      <= '0;
      remaining  <= '0;
      outData    <= '0;
      outInvalid <= 1'b0;
      outInexact <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sgnR      <= inSign;
          signedR   <= inSigned;
          roundR    <= inRound;
          mag       <= '0;
          remaining <= RW'(eVal + 1);
          // Below one half the whole significand is sticky; guard is the hidden bit only at e = -1
          sigSh     <= (eVal < -1) ? SW'(1) : {1'b1, inMan};
          if (isZero) begin
            outData    <= '0;
            outInvalid <= 1'b0;
            outInexact <= 1'b0;
          end else if (overflow) begin
            outData    <= satIn;
            outInvalid <= 1'b1;
            outInexact <= 1'b0;
          end
        end
        SHIFT: begin
          mag       <= magShift;
          sigSh     <= sigSh << n;
          remaining <= remaining - n;
        end
        ROUND: begin
          if (inRange) begin
            outData    <= result;
            outInvalid <= 1'b0;
            outInexact <= guard || sticky;
          end else begin
            outData    <= satR;
            outInvalid <= 1'b1;
            outInexact <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int_iter.sv
module tb_float_to_int_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inTrigger;
  logic [31:0] inData;
  logic        inSigned;
  logic        inRound;
  logic        outReady;
  logic        outInvalid;
  logic        outInexact;
  logic [63:0] outData;

  int nChk  = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  float_to_int_iter #(.EXP_W(8), .MAN_W(23), .INT_W(64), .BPC(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inTrigger  (inTrigger),
    .inData     (inData),
    .inSigned   (inSigned),
    .inRound    (inRound),
    .outReady   (outReady),
    .outInvalid (outInvalid),
    .outInexact (outInexact),
    .outData    (outData)
  );

  typedef struct {
    logic [63:0] d;
    bit          inv;
    bit          inx;
    int          lat;
  } res_t;

  // Reference: scale the exact value by 2^64 so the integer part and the
  // discarded fraction are plain bit fields; round and range-check numerically.
  function automatic res_t refConv(input logic [31:0] f, input bit sgnd, input bit rnd);
    res_t         r;
    logic [7:0]   ex;
    logic [22:0]  mn;
    bit           neg;
    int           e;
    logic [191:0] x;
    logic [127:0] ip;
    logic [63:0]  fr;
    logic [63:0]  hiSat, loSat;
    bit           bad;
    ex    = f[30:23];
    mn    = f[22:0];
    neg   = f[31];
    e     = int'(ex) - 127;
    hiSat = sgnd ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    loSat = sgnd ? 64'h8000_0000_0000_0000 : 64'h0;
    r.d = 64'h0; r.inv = 0; r.inx = 0; r.lat = 0;
    if (ex == 8'd0) return r;
    if (ex == 8'hFF) begin
      r.inv = 1;
      r.d   = (mn != 0 || neg) ? loSat : hiSat;
      return r;
    end
    if (e >= 64) begin
      r.inv = 1;
      r.d   = neg ? loSat : hiSat;
      return r;
    end
    r.lat = (e < 0) ? 1 : (e + 4) / 4 + 1;
    if (e <= -2) begin
      ip = 128'h0;
      fr = 64'h1;            // non-zero, far below one half
    end else begin
      x  = 192'({1'b1, mn}) << (e + 41);
      ip = x[191:64];
      fr = x[63:0];
    end
    if (rnd && (fr > 64'h8000_0000_0000_0000 ||
                (fr == 64'h8000_0000_0000_0000 && ip[0])))
      ip = ip + 128'h1;
    if (sgnd) bad = neg ? (ip > 128'h8000_0000_0000_0000) : (ip > 128'h7FFF_FFFF_FFFF_FFFF);
    else      bad = neg ? (ip != 128'h0) : (ip > 128'hFFFF_FFFF_FFFF_FFFF);
    if (bad) begin
      r.inv = 1;
      r.d   = neg ? loSat : hiSat;
    end else begin
      r.d   = neg ? -ip[63:0] : ip[63:0];
      r.inx = (fr != 64'h0);
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s @%0t: got=%h expected=%h", nm, $time, got, exp);
    end
  endtask

  task automatic pin(input string nm, input logic [31:0] f, input bit s, input bit r,
                     input logic [63:0] d, input bit inv, input bit inx, input int lat);
    res_t m;
    m = refConv(f, s, r);
    chk({nm, ".d"},   m.d, d);
    chk({nm, ".inv"}, 64'(m.inv), 64'(inv));
    chk({nm, ".inx"}, 64'(m.inx), 64'(inx));
    chk({nm, ".lat"}, 64'(m.lat), 64'(lat));
  endtask

  // Compare process: step the model on every edge, check all outputs 2ns later.
  res_t cur, pend, tmp;
  int   mLeft = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mLeft = 0;
      cur.d = 64'h0; cur.inv = 0; cur.inx = 0; cur.lat = 0;
    end else if (mLeft == 0) begin
      if (inTrigger) begin
        tmp = refConv(inData, inSigned, inRound);
        if (tmp.lat == 0) cur = tmp;
        else begin
          mLeft = tmp.lat;
          pend  = tmp;
        end
      end
    end else begin
      mLeft--;
      if (mLeft == 0) cur = pend;
    end
    #2;
    chk("outReady",   64'(outReady),   64'(mLeft == 0));
    chk("outData",    outData,         cur.d);
    chk("outInvalid", 64'(outInvalid), 64'(cur.inv));
    chk("outInexact", 64'(outInexact), 64'(cur.inx));
  end

  task automatic waitReady();
    int k = 0;
    while (!outReady && k < 40) begin
      @(negedge clk);
      k++;
    end
    nChk++;
    if (!outReady) begin
      nFail++;
      $display("FAIL ready_timeout @%0t: got=outReady 0 expected=outReady 1 within 40 cycles", $time);
    end
  endtask

  task automatic doConv(input logic [31:0] f, input bit s, input bit r);
    waitReady();
    inData    = f;
    inSigned  = s;
    inRound   = r;
    inTrigger = 1'b1;
    @(negedge clk);
    inTrigger = 1'b0;
    inData    = $urandom;   // later input changes must not disturb the conversion
    inSigned  = 1'($urandom);
    inRound   = 1'($urandom);
    @(negedge clk);
    waitReady();
  endtask

  function automatic logic [31:0] randFloat();
    int          cat;
    logic [7:0]  ex;
    logic [22:0] mn;
    cat = $urandom_range(0, 15);
    if (cat == 0)      ex = 8'd0;
    else if (cat == 1) ex = 8'hFF;
    else if (cat == 2) ex = 8'($urandom_range(0, 255));
    else               ex = 8'($urandom_range(110, 192));
    mn = 23'($urandom);
    if ($urandom_range(0, 1) == 1) mn = mn & (23'h7FFFFF << $urandom_range(0, 22));
    return {1'($urandom), ex, mn};
  endfunction

  initial begin
    rst_n     = 1'b0;
    inTrigger = 1'b0;
    inData    = 32'h0;
    inSigned  = 1'b0;
    inRound   = 1'b0;

    // Hand-computed expectations that pin the reference model
    pin("p2.5rne",   32'h40200000, 1, 1, 64'h2, 0, 1, 2);
    pin("p3.5rne",   32'h40600000, 1, 1, 64'h4, 0, 1, 2);
    pin("p3.5trc",   32'h40600000, 1, 0, 64'h3, 0, 1, 2);
    pin("pm1.5s",    32'hBFC00000, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 2);
    pin("pm1.5u",    32'hBFC00000, 0, 0, 64'h0, 1, 0, 2);
    pin("p2^63s",    32'h5F000000, 1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 0, 17);
    pin("p2^63u",    32'h5F000000, 0, 0, 64'h8000_0000_0000_0000, 0, 0, 17);
    pin("pm2^63s",   32'hDF000000, 1, 0, 64'h8000_0000_0000_0000, 0, 0, 17);
    pin("pnan",      32'h7FC00000, 1, 0, 64'h8000_0000_0000_0000, 1, 0, 0);
    pin("pminf",     32'hFF800000, 1, 0, 64'h8000_0000_0000_0000, 1, 0, 0);
    pin("pmzero",    32'h80000000, 1, 1, 64'h0, 0, 0, 0);
    pin("p0.5",      32'h3F000000, 1, 1, 64'h0, 0, 1, 1);
    pin("p0.75",     32'h3F400000, 1, 1, 64'h1, 0, 1, 1);
    pin("p24bit",    32'h4B7FFFFF, 0, 1, 64'hFF_FFFF, 0, 0, 7);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed conversions through the DUT
    doConv(32'h40200000, 1, 1);
    doConv(32'h40600000, 1, 1);
    doConv(32'h40600000, 1, 0);
    doConv(32'hBFC00000, 1, 0);
    doConv(32'hBFC00000, 0, 0);
    doConv(32'h5F000000, 1, 0);
    doConv(32'h5F000000, 0, 0);
    doConv(32'hDF000000, 1, 0);
    doConv(32'h7FC00000, 1, 0);
    doConv(32'hFF800000, 1, 0);
    doConv(32'h80000000, 1, 1);
    doConv(32'h3F000000, 1, 1);
    doConv(32'h3F400000, 1, 1);
    doConv(32'h4B7FFFFF, 0, 1);

    // Busy trigger is ignored, then reset aborts a long conversion
    waitReady();
    inData = 32'h5F000000; inSigned = 1'b1; inRound = 1'b0; inTrigger = 1'b1;
    @(negedge clk);
    inTrigger = 1'b0;
    repeat (3) @(negedge clk);
    inData = 32'h3F800000; inTrigger = 1'b1;
    @(negedge clk);
    inTrigger = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_ready",   64'(outReady),   64'h1);
    chk("rst_data",    outData,         64'h0);
    chk("rst_invalid", 64'(outInvalid), 64'h0);
    chk("rst_inexact", 64'(outInexact), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    doConv(32'h40600000, 1, 0);

    // Randomized traffic: triggers land both while idle and while busy
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      inTrigger = ($urandom_range(0, 2) != 0);
      inData    = randFloat();
      inSigned  = 1'($urandom);
      inRound   = 1'($urandom);
    end
    @(negedge clk);
    inTrigger = 1'b0;
    waitReady();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nChk, nFail);
    $finish;
  end

endmodule
